// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result stage: op codes, buffer states, field widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

    // Entry payload field widths (defaults for the stage parameters).
    localparam int OP_W        = 3;
    localparam int WIDTH_DEF   = 16;
    localparam int RD_W_DEF    = 3;

    // Legal ALU mux selects; anything above ALU_OP_MAX is not a real operation.
    localparam logic [OP_W-1:0] ALU_OP_AND = 3'd0;
    localparam logic [OP_W-1:0] ALU_OP_OR  = 3'd1;
    localparam logic [OP_W-1:0] ALU_OP_ADD = 3'd2;
    localparam logic [OP_W-1:0] ALU_OP_SUB = 3'd3;
    localparam logic [OP_W-1:0] ALU_OP_SLT = 3'd4;
    localparam logic [OP_W-1:0] ALU_OP_MAX = 3'd4;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    function automatic logic op_is_illegal(input logic [OP_W-1:0] op);
        return (op > ALU_OP_MAX);
    endfunction

endpackage

// File: rtl/alu_flag_gen.sv
// Zero/negative flag derivation for an ALU result.
// Latency: combinational, 0 cycles.
// Backpressure: none (pure function of i_result).
//
// Ports:
//   i_result  WIDTH-bit ALU result
//   o_zero    1 when i_result is all zeros
//   o_neg     sign bit of i_result
module alu_flag_gen #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] i_result,
    output logic             o_zero,
    output logic             o_neg
);

    assign o_zero = (i_result == '0);
    assign o_neg  = i_result[WIDTH-1];

endmodule

// File: rtl/alu_result_stage.sv
// Execute-to-writeback stage: buffers ALU result + rd/wen/op with zero/neg flags.
// Latency: 1 cycle from input transfer to out_valid when empty; 1 entry/cycle sustained.
// Backpressure: 2-entry skid buffer, in_ready registered and low only while both entries are held.
//
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   flush                 synchronous discard of all buffered entries
//   in_valid/in_ready     upstream handshake; in_result/in_operation/in_rd/in_wen payload
//   out_valid/out_ready   writeback handshake; out_result/out_operation/out_rd/out_wen payload
//   out_zero, out_neg     flags of out_result, captured with the entry
//   illegal_op            (only with ALU_RESULT_STAGE_ILLEGAL_OP_EN) sticky flag, an
//                         operation code above ALU_OP_MAX was accepted; cleared by reset only
//
// Optional feature macro: ALU_RESULT_STAGE_ILLEGAL_OP_EN. When defined, entries with an
// illegal operation code are accepted but stored with wen=0 and set illegal_op.
module alu_result_stage
    import alu_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int RD_W  = RD_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_result,
    input  logic [OP_W-1:0]  in_operation,
    input  logic [RD_W-1:0]  in_rd,
    input  logic             in_wen,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic [OP_W-1:0]  out_operation,
    output logic [RD_W-1:0]  out_rd,
    output logic             out_wen,
    output logic             out_zero,
    output logic             out_neg
`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
    ,
    output logic             illegal_op
`endif
);

    typedef struct packed {
        logic [WIDTH-1:0] result;
        logic [OP_W-1:0]  op;
        logic [RD_W-1:0]  rd;
        logic             wen;
        logic             zero;
        logic             neg;
    } entry_t;

    // Reset image of an entry: result 0 means the zero flag is set.
    localparam entry_t ENTRY_RST = '{result: '0, op: '0, rd: '0, wen: 1'b0,
                                     zero: 1'b1, neg: 1'b0};

    state_t r_state;
    state_t w_state_nxt;
    logic   r_in_ready;
    entry_t r_main;
    entry_t r_skid;
    entry_t w_in_entry;

    logic   w_zero;
    logic   w_neg;
    logic   w_in_xfer;
    logic   w_out_xfer;
    logic   w_out_valid;
    logic   w_main_ld_in;
    logic   w_main_ld_skid;
    logic   w_skid_ld;

    // ------------------------------------------------------------------
    // Input entry assembly; flags are computed once here and travel with
    // the entry so they are valid whenever it is presented downstream.
    // ------------------------------------------------------------------
    alu_flag_gen #(
        .WIDTH (WIDTH)
    ) u_flag_gen (
        .i_result (in_result),
        .o_zero   (w_zero),
        .o_neg    (w_neg)
    );

`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
    logic w_illegal;
    assign w_illegal = op_is_illegal(in_operation);
`endif

    always_comb begin
        w_in_entry        = ENTRY_RST;
        w_in_entry.result = in_result;
        w_in_entry.op     = in_operation;
        w_in_entry.rd     = in_rd;
`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
        w_in_entry.wen    = in_wen & ~w_illegal;
`else
        w_in_entry.wen    = in_wen;
`endif
        w_in_entry.zero   = w_zero;
        w_in_entry.neg    = w_neg;
    end

    // ------------------------------------------------------------------
    // Handshakes
    // ------------------------------------------------------------------
    assign w_out_valid = (r_state != EMPTY);
    assign w_in_xfer   = in_valid & r_in_ready;
    assign w_out_xfer  = w_out_valid & out_ready;

    // ------------------------------------------------------------------
    // FSM: state register (in_ready is registered alongside so it always
    // equals "state != FULL" without a combinational path from out_ready).
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
        end
    end

    // FSM: next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            EMPTY: begin
                if (w_in_xfer) w_state_nxt = ONE;
            end
            ONE: begin
                if (w_in_xfer && !w_out_xfer)      w_state_nxt = FULL;
                else if (!w_in_xfer && w_out_xfer) w_state_nxt = EMPTY;
            end
            FULL: begin
                if (w_out_xfer) w_state_nxt = ONE;
            end
            default: w_state_nxt = EMPTY;
        endcase
        // Flush drops everything, including an input offered this cycle.
        if (flush) w_state_nxt = EMPTY;
    end

    // FSM: datapath load controls
    always_comb begin
        w_main_ld_in   = 1'b0;
        w_main_ld_skid = 1'b0;
        w_skid_ld      = 1'b0;
        if (!flush) begin
            case (r_state)
                EMPTY: w_main_ld_in = w_in_xfer;
                ONE: begin
                    // Simultaneous in/out keeps occupancy at one: main reloads.
                    w_main_ld_in = w_in_xfer & w_out_xfer;
                    w_skid_ld    = w_in_xfer & ~w_out_xfer;
                end
                FULL:    w_main_ld_skid = w_out_xfer;
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Entry storage: only written on an explicit load, so the presented
    // payload is stable while the consumer stalls.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_main <= ENTRY_RST;
            r_skid <= ENTRY_RST;
        end else begin
            if (w_main_ld_in) begin
                r_main <= w_in_entry;
            end else if (w_main_ld_skid) begin
                r_main <= r_skid;
            end
            if (w_skid_ld) begin
                r_skid <= w_in_entry;
            end
        end
    end

`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
    logic r_illegal_op;

    // Sticky: set only by an entry actually accepted (not one dropped by flush).
    always_ff @(posedge clk) begin
        if (reset) begin
            r_illegal_op <= 1'b0;
        end else if (w_in_xfer && !flush && w_illegal) begin
            r_illegal_op <= 1'b1;
        end
    end

    assign illegal_op = r_illegal_op;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready      = r_in_ready;
    assign out_valid     = w_out_valid;
    assign out_result    = r_main.result;
    assign out_operation = r_main.op;
    assign out_rd        = r_main.rd;
    assign out_wen       = r_main.wen & w_out_valid;
    assign out_zero      = r_main.zero;
    assign out_neg       = r_main.neg;

endmodule

// File: tb/tb_alu_result_stage.sv
// Self-checking bench for alu_result_stage: directed steps with a FIFO scoreboard.
// Latency: n/a (testbench).
// Backpressure: out_ready driven directly by the steps below.
module tb_alu_result_stage;

    localparam int W  = 16;
    localparam int RW = 3;

    logic          clk;
    logic          reset;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_result;
    logic [2:0]    in_operation;
    logic [RW-1:0] in_rd;
    logic          in_wen;
    logic          out_valid;
    logic          out_ready;
    logic [W-1:0]  out_result;
    logic [2:0]    out_operation;
    logic [RW-1:0] out_rd;
    logic          out_wen;
    logic          out_zero;
    logic          out_neg;
`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
    logic          illegal_op;
`endif

    alu_result_stage #(
        .WIDTH (W),
        .RD_W  (RW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_result     (in_result),
        .in_operation  (in_operation),
        .in_rd         (in_rd),
        .in_wen        (in_wen),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_result    (out_result),
        .out_operation (out_operation),
        .out_rd        (out_rd),
        .out_wen       (out_wen),
        .out_zero      (out_zero),
        .out_neg       (out_neg)
`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
        ,
        .illegal_op    (illegal_op)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0]  res;
        logic [2:0]    op;
        logic [RW-1:0] rd;
        logic          wen;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    logic exp_illegal = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [W-1:0] r, input logic [2:0] op,
                         input logic [RW-1:0] rd, input logic wen, input logic ordy,
                         input logic fl);
        in_valid     = v;
        in_result    = r;
        in_operation = op;
        in_rd        = rd;
        in_wen       = wen;
        out_ready    = ordy;
        flush        = fl;
    endtask

    // Called just after a falling edge with inputs already driven: compares the
    // DUT against the model, updates the model for the coming rising edge, and
    // advances to the next falling edge.
    task automatic tick();
        logic exp_valid;
        logic exp_ready;
        exp_t e;
        exp_valid = (q.size() != 0);
        exp_ready = (q.size() < 2);
        chk("out_valid", 32'(out_valid), 32'(exp_valid));
        chk("in_ready", 32'(in_ready), 32'(exp_ready));
        if (exp_valid) begin
            chk("out_result", 32'(out_result), 32'(q[0].res));
            chk("out_operation", 32'(out_operation), 32'(q[0].op));
            chk("out_rd", 32'(out_rd), 32'(q[0].rd));
            chk("out_wen", 32'(out_wen), 32'(q[0].wen));
            chk("out_zero", 32'(out_zero), 32'(q[0].res == '0));
            chk("out_neg", 32'(out_neg), 32'(q[0].res[W-1]));
        end else begin
            chk("out_wen_idle", 32'(out_wen), 32'(0));
        end
`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
        chk("illegal_op", 32'(illegal_op), 32'(exp_illegal));
`endif
        if (reset) begin
            q.delete();
            exp_illegal = 1'b0;
        end else begin
            if (exp_valid && out_ready) void'(q.pop_front());
            if (flush) begin
                q.delete();
            end else if (in_valid && exp_ready) begin
                e.res = in_result;
                e.op  = in_operation;
                e.rd  = in_rd;
`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
                e.wen = in_wen & (in_operation <= 3'd4);
                if (in_operation > 3'd4) exp_illegal = 1'b1;
`else
                e.wen = in_wen;
`endif
                q.push_back(e);
            end
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_reset_values();
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_in_ready", 32'(in_ready), 32'(1));
        chk("rst_out_result", 32'(out_result), 32'(0));
        chk("rst_out_operation", 32'(out_operation), 32'(0));
        chk("rst_out_rd", 32'(out_rd), 32'(0));
        chk("rst_out_wen", 32'(out_wen), 32'(0));
        chk("rst_out_zero", 32'(out_zero), 32'(1));
        chk("rst_out_neg", 32'(out_neg), 32'(0));
`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
        chk("rst_illegal_op", 32'(illegal_op), 32'(0));
`endif
    endtask

    initial begin
        reset = 1'b1;
        drive(1'b1, 16'h1111, 3'd2, 3'd1, 1'b1, 1'b1, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk_reset_values();
        reset = 1'b0;

        // First entry: zero result, one-cycle latency.
        drive(1'b1, 16'h0000, 3'd2, 3'd3, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 16'h0000, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("first_valid", 32'(out_valid), 32'(1));
        chk("first_zero", 32'(out_zero), 32'(1));
        chk("first_neg", 32'(out_neg), 32'(0));
        chk("first_rd", 32'(out_rd), 32'(3));
        tick();

        // Back-to-back stream 1..4 with the consumer always ready.
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 16'(i), 3'(i), 3'(i), 1'b1, 1'b1, 1'b0);
            tick();
            chk("stream_in_ready", 32'(in_ready), 32'(1));
            chk("stream_result", 32'(out_result), 32'(i));
        end
        drive(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();

        // Fill to FULL under backpressure; a third offer must be refused.
        drive(1'b1, 16'h8001, 3'd3, 3'd5, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0005, 3'd1, 3'd6, 1'b0, 1'b0, 1'b0);
        tick();
        chk("full_in_ready", 32'(in_ready), 32'(0));
        drive(1'b1, 16'h0777, 3'd0, 3'd7, 1'b1, 1'b0, 1'b0);
        tick();
        tick();
        drive(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("drain_first_neg", 32'(out_neg), 32'(1));
        tick();
        chk("drain_in_ready_back", 32'(in_ready), 32'(1));
        chk("drain_second", 32'(out_result), 32'(16'h0005));
        tick();
        tick();

        // FULL, then flush with an offered entry: nothing survives.
        drive(1'b1, 16'h00A0, 3'd0, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h00A1, 3'd1, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'hDEAD, 3'd2, 3'd3, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        chk("flush_out_valid", 32'(out_valid), 32'(0));
        chk("flush_in_ready", 32'(in_ready), 32'(1));
        tick();
        tick();

        // Flush in ONE with the output consumed in the same cycle.
        drive(1'b1, 16'h0042, 3'd4, 3'd4, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b1, 16'h0043, 3'd4, 3'd4, 1'b1, 1'b1, 1'b1);
        tick();
        drive(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();

        // Reset mid-stream with two entries held.
        drive(1'b1, 16'hF00F, 3'd3, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h0F0F, 3'd2, 3'd1, 1'b1, 1'b0, 1'b0);
        tick();
        reset = 1'b1;
        drive(1'b1, 16'h1234, 3'd1, 3'd1, 1'b1, 1'b0, 1'b1);
        tick();
        chk_reset_values();
        reset = 1'b0;
        drive(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();

        // Illegal operation code with wen requested.
        drive(1'b1, 16'h1234, 3'd6, 3'd2, 1'b1, 1'b0, 1'b0);
        tick();
`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
        chk("illegal_wen", 32'(out_wen), 32'(0));
        chk("illegal_flag", 32'(illegal_op), 32'(1));
`else
        chk("passthru_wen", 32'(out_wen), 32'(1));
`endif
        drive(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1);
        tick();
`ifdef ALU_RESULT_STAGE_ILLEGAL_OP_EN
        chk("illegal_sticky_flush", 32'(illegal_op), 32'(1));
`endif
        drive(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();

        // Randomised traffic with intermittent backpressure and flushes.
        for (int i = 0; i < 60; i++) begin
            drive(1'($urandom_range(0, 1)), 16'($urandom), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 15) == 0));
            tick();
        end
        drive(1'b0, 16'h0, 3'd0, 3'd0, 1'b0, 1'b1, 1'b0);
        tick();
        tick();
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
